// File: rtl/matmul_result_reader.sv
// Reads the A*C-word result RAM in address order and streams each word out LSB byte first.
// Define MATMUL_RD_CHECKSUM_EN to append a trailing XOR-of-all-bytes checksum byte.
module matmul_result_reader #(
  parameter  int A        = 16,
  parameter  int C        = 24,
  parameter  int OUT_BITS = 32,
  localparam int M3_L     = A * C,
  localparam int NBYTES   = OUT_BITS / 8,
  localparam int AW       = (M3_L > 1) ? $clog2(M3_L) : 1,
  localparam int BW       = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [AW-1:0]       m3_rd_addr,
  input  logic [OUT_BITS-1:0] m3_rd_data,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] WLAST = AW'(M3_L - 1);
  localparam logic [BW-1:0] BLAST = BW'(NBYTES - 1);

`ifdef MATMUL_RD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, CSUM} state_t;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND} state_t;
`endif

  state_t              state_q;
  logic [AW-1:0]       wcnt_q;
  logic [BW-1:0]       bcnt_q;
  logic [OUT_BITS-1:0] sh_q;
  logic                vld_q;
  logic                done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MATMUL_RD_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          wcnt_q  <= '0;
`ifdef MATMUL_RD_CHECKSUM_EN
          csum_q  <= '0;
`endif
          state_q <= READ;
        end
        // Address is presented this cycle; the RAM returns data next cycle.
        READ: state_q <= LOAD;
        LOAD: begin
          sh_q    <= m3_rd_data;
          bcnt_q  <= '0;
          vld_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (out_ready) begin
          sh_q   <= sh_q >> 8;
          bcnt_q <= bcnt_q + 1'b1;
`ifdef MATMUL_RD_CHECKSUM_EN
          csum_q <= csum_q ^ sh_q[7:0];
`endif
          if (bcnt_q == BLAST) begin
            if (wcnt_q == WLAST) begin
`ifdef MATMUL_RD_CHECKSUM_EN
              state_q <= CSUM;
`else
              vld_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end else begin
              vld_q   <= 1'b0;
              wcnt_q  <= wcnt_q + 1'b1;
              state_q <= READ;
            end
          end
        end
`ifdef MATMUL_RD_CHECKSUM_EN
        CSUM: if (out_ready) begin
          vld_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m3_rd_addr = wcnt_q;
  assign out_valid  = vld_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
`ifdef MATMUL_RD_CHECKSUM_EN
  assign out_data   = (state_q == CSUM) ? csum_q : sh_q[7:0];
`else
  assign out_data   = sh_q[7:0];
`endif

endmodule

// File: tb/tb_matmul_result_reader.sv
// Self-checking bench for matmul_result_reader (A=2, C=2, OUT_BITS=32): table-driven runs
// against a byte-queue reference model, plus reset-mid-word and start-held sequences.
module tb_matmul_result_reader;
  localparam int L  = 4;
  localparam int NB = 4;
`ifdef MATMUL_RD_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, out_ready, out_valid, busy, done;
  logic [1:0]  addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;
  logic [31:0] ram [L];

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= ram[addr];

  matmul_result_reader #(.A(2), .C(2), .OUT_BITS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .m3_rd_addr(addr), .m3_rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [3:0]       rpat;     // ready pattern, bit (n%4) drives cycle n
    logic             rnd_ram;
    logic             rnd_rdy;
    logic [7:0]       restart;  // cycle of a stray start pulse, 0 = none
    logic [7:0]       exp_lat;  // first out_valid cycle after start is sampled
  } vec_t;

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$], got_q[$];
  int hs_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every word in address order, low byte first, then optional XOR byte.
  function automatic void build_exp();
    logic [7:0] x = 8'h00;
    logic [31:0] wd;
    exp_q.delete();
    for (int w = 0; w < L; w++) begin
      wd = ram[w];
      for (int k = 0; k < NB; k++) begin
        exp_q.push_back(wd[8*k +: 8]);
        x ^= wd[8*k +: 8];
      end
    end
    if (CS != 0) exp_q.push_back(x);
  endfunction

  task automatic run(input logic [3:0] rpat, input bit rnd_rdy, input int restart, input int exp_lat);
    int first = -1, dones = 0, done_n = -1, last_hs = -1, n = 0;
    bit prev_stall = 0, rdy;
    logic [7:0] prev_data = 8'h00;
    build_exp();
    got_q.delete();
    hs_q.delete();
    @(negedge clk);
    start = 1'b1;
    while (n < 2000 && !(done_n >= 0 && n >= done_n + 3)) begin
      @(negedge clk);
      n++;
      start = (n == restart);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && first < 0) first = n;
      if (done) begin
        dones++;
        if (done_n < 0) done_n = n;
        chk("busy_at_done", busy, 0);
      end
      rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : rpat[n % 4];
      out_ready = rdy;
      if (out_valid && rdy) begin
        got_q.push_back(out_data);
        hs_q.push_back(n);
        last_hs = n;
      end
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
    end
    start = 1'b0;
    chk("done_seen", done_n >= 0, 1);
    chk("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    chk("done_count", dones, 1);
    chk("done_after_last", done_n, last_hs + 1);
    chk("first_valid_lat", first, exp_lat);
    if (rpat == 4'hF && !rnd_rdy)
      for (int i = 0; i < L * NB && i < hs_q.size(); i++)
        chk($sformatf("hs_cycle%0d", i), hs_q[i], 3 + (NB + 2) * (i / NB) + i % NB);
  endtask

  vec_t vt[8];

  initial begin
    int cnt, d;
    bit seen;
    vt[0] = '{w: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
              rpat: 4'hF, rnd_ram: 0, rnd_rdy: 0, restart: 0, exp_lat: 3};
    vt[1] = vt[0]; vt[1].rpat = 4'b1001;
    vt[2] = vt[0]; vt[2].restart = 8'd10;
    vt[3] = vt[0]; vt[3].w[0] = 32'h000000FF;
    vt[4] = vt[0]; vt[4].rnd_ram = 1; vt[4].rnd_rdy = 1;
    vt[5] = vt[4];
    vt[6] = vt[4]; vt[6].restart = 8'd7;
    vt[7] = vt[0]; vt[7].rnd_ram = 1; vt[7].rpat = 4'b0101;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < L; i++) ram[i] = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < L; i++) ram[i] = vt[t].rnd_ram ? $urandom : vt[t].w[i];
      run(vt[t].rpat, vt[t].rnd_rdy, int'(vt[t].restart), int'(vt[t].exp_lat));
    end

    // Reset after 5 accepted bytes, then a fresh readout must replay from byte 0.
    for (int i = 0; i < L; i++) ram[i] = vt[0].w[i];
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; cnt = 0;
    for (int n = 0; n < 200 && cnt < 5; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) cnt++;
    end
    chk("rst_mid_accepted", cnt, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", addr, 0);
    rst = 1'b0;
    run(4'hF, 0, 0, 3);

    // start held high: next readout begins the first IDLE cycle after done.
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; seen = 0; d = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    chk("held_done_seen", seen, 1);
    chk("held_busy_at_done", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("held_restart_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("held_restart_valid", out_valid, 1);
    chk("held_restart_byte0", out_data, 8'h00);
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = done;
      if (out_valid) d++;
    end
    chk("held_second_done", seen, 1);
    chk("held_second_len", d + 1, L * NB + CS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
